// File: rtl/alu_writeback.sv
// alu_writeback: registered writeback stage behind the 8-bit ALU.
// Buffers up to two results in order for the register-file write port,
// holds the architectural Zero flag and the shift-carry register, and
// forwards the youngest pending register write to operand select.
module alu_writeback #(
    parameter int DW = 8,
    parameter int RW = 3
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          InValid,
    output logic          InReady,
    input  logic [DW-1:0] InData,
    input  logic          InZero,
    input  logic          InSC,
    input  logic [RW-1:0] InDest,
    input  logic          InWrEn,
    input  logic          InSCWr,
    input  logic          Flush,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [DW-1:0] OutData,
    output logic [RW-1:0] OutDest,
    output logic          OutWrEn,
    output logic          SC_out,
    output logic          ZeroFlag,
    output logic          FwdValid,
    output logic [RW-1:0] FwdDest,
    output logic [DW-1:0] FwdData,
    output logic [1:0]    Count
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] dest;
        logic          wren;
    } wb_entry_t;

    wb_entry_t [1:0] mem;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    logic            zero_q;
    logic            sc_q;
    wb_entry_t       head;
    wb_entry_t       young;

    // Handshake status depends only on registered occupancy.
    assign InReady  = (count != 2'd2);
    assign OutValid = (count != 2'd0);
    assign push     = InValid & InReady & ~Flush;
    assign pop      = OutValid & OutReady & ~Flush;

    // With two entries the pointers coincide, so the younger entry sits opposite the head.
    assign head  = mem[rd_ptr];
    assign young = mem[~rd_ptr];

    assign OutData  = head.data;
    assign OutDest  = head.dest;
    assign OutWrEn  = head.wren;
    assign Count    = count;
    assign ZeroFlag = zero_q;
    assign SC_out   = sc_q;

    // Buffer storage, pointers and occupancy; flush drops everything in one edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mem    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (Flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: InData, dest: InDest, wren: InWrEn};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Flags follow accepted results, not retirements, and survive a flush.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            zero_q <= 1'b0;
            sc_q   <= 1'b0;
        end else if (push) begin
            zero_q <= InZero;
            if (InSCWr)
                sc_q <= InSC;
        end
    end

    // Forward the youngest buffered entry that will write the register file.
    always_comb begin
        FwdValid = 1'b0;
        FwdDest  = '0;
        FwdData  = '0;
        if (count == 2'd2 && young.wren) begin
            FwdValid = 1'b1;
            FwdDest  = young.dest;
            FwdData  = young.data;
        end else if (count != 2'd0 && head.wren) begin
            FwdValid = 1'b1;
            FwdDest  = head.dest;
            FwdData  = head.data;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed and randomized checks of alu_writeback
// against an in-order queue model of the writeback buffer.
module tb_alu_writeback;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       InValid, InZero, InSC, InWrEn, InSCWr, Flush, OutReady;
    logic [7:0] InData;
    logic [2:0] InDest;
    logic       InReady, OutValid, OutWrEn, SC_out, ZeroFlag, FwdValid;
    logic [7:0] OutData, FwdData;
    logic [2:0] OutDest, FwdDest;
    logic [1:0] Count;

    alu_writeback #(.DW(8), .RW(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .InValid(InValid), .InReady(InReady), .InData(InData), .InZero(InZero),
        .InSC(InSC), .InDest(InDest), .InWrEn(InWrEn), .InSCWr(InSCWr),
        .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
        .OutData(OutData), .OutDest(OutDest), .OutWrEn(OutWrEn),
        .SC_out(SC_out), .ZeroFlag(ZeroFlag), .FwdValid(FwdValid),
        .FwdDest(FwdDest), .FwdData(FwdData), .Count(Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] r;
        logic       w;
    } ent_t;

    ent_t q[$];
    logic m_zf, m_sc;
    logic last_acc;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Compare every output against the model's current state.
    task automatic check_all(input string tag);
        logic       fv;
        logic [7:0] fd;
        logic [2:0] fr;
        fv = 1'b0; fd = '0; fr = '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (!fv && q[i].w) begin
                fv = 1'b1; fd = q[i].d; fr = q[i].r;
            end
        chk({tag, ".count"},    32'(Count),    32'(q.size()));
        chk({tag, ".inready"},  32'(InReady),  32'(q.size() != 2));
        chk({tag, ".outvalid"}, 32'(OutValid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".outdata"}, 32'(OutData), 32'(q[0].d));
            chk({tag, ".outdest"}, 32'(OutDest), 32'(q[0].r));
            chk({tag, ".outwren"}, 32'(OutWrEn), 32'(q[0].w));
        end
        chk({tag, ".zero"},     32'(ZeroFlag), 32'(m_zf));
        chk({tag, ".sc"},       32'(SC_out),   32'(m_sc));
        chk({tag, ".fwdvalid"}, 32'(FwdValid), 32'(fv));
        chk({tag, ".fwddest"},  32'(FwdDest),  32'(fr));
        chk({tag, ".fwddata"},  32'(FwdData),  32'(fd));
    endtask

    task automatic model_reset();
        q.delete();
        m_zf = 1'b0;
        m_sc = 1'b0;
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model at
    // the edge, then check outputs at the following negedge.
    task automatic step(input string tag, input logic iv, input logic [7:0] d,
                        input logic z, input logic sc, input logic [2:0] r,
                        input logic we, input logic scw, input logic fl,
                        input logic ordy);
        logic do_push, do_pop;
        InValid = iv; InData = d; InZero = z; InSC = sc; InDest = r;
        InWrEn = we; InSCWr = scw; Flush = fl; OutReady = ordy;
        @(posedge Clk);
        do_push = iv && q.size() != 2 && !fl;
        do_pop  = q.size() != 0 && ordy && !fl;
        last_acc = do_push;
        if (fl) q.delete();
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back('{d: d, r: r, w: we});
            m_zf = z;
            if (scw) m_sc = sc;
        end
        @(negedge Clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic ordy);
        step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ordy);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".count"},    32'(Count),    32'd0);
        chk({tag, ".outvalid"}, 32'(OutValid), 32'd0);
        chk({tag, ".inready"},  32'(InReady),  32'd1);
        chk({tag, ".fwdvalid"}, 32'(FwdValid), 32'd0);
        chk({tag, ".outdata"},  32'(OutData),  32'd0);
        chk({tag, ".outdest"},  32'(OutDest),  32'd0);
        chk({tag, ".outwren"},  32'(OutWrEn),  32'd0);
        chk({tag, ".zero"},     32'(ZeroFlag), 32'd0);
        chk({tag, ".sc"},       32'(SC_out),   32'd0);
    endtask

    initial begin
        logic       iv, z, sc, we, scw, fl, ordy;
        logic [7:0] d;
        logic [2:0] r;
        logic       zf_save, sc_save;

        Reset_n = 1'b0;
        InValid = 0; InData = 0; InZero = 0; InSC = 0; InDest = 0;
        InWrEn = 0; InSCWr = 0; Flush = 0; OutReady = 0;
        model_reset();
        last_acc = 1'b0;
        repeat (2) @(negedge Clk);
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        // Single push, then pop.
        step("single_push", 1, 8'h02, 0, 0, 3'd3, 1, 0, 0, 1);
        chk("single.data", 32'(OutData), 32'h02);
        chk("single.fwd",  32'(FwdDest), 32'd3);
        idle("single_pop", 1);
        chk("single.empty", 32'(Count), 32'd0);

        // Backpressure: fill, reject a third, then drain in order.
        step("bp_push1", 1, 8'h10, 0, 0, 3'd1, 1, 0, 0, 0);
        step("bp_push2", 1, 8'h20, 0, 0, 3'd2, 1, 0, 0, 0);
        chk("bp.inready", 32'(InReady), 32'd0);
        chk("bp.fwddata", 32'(FwdData), 32'h20);
        step("bp_push3", 1, 8'h30, 0, 0, 3'd4, 1, 0, 0, 0);
        chk("bp.full_hold", 32'(Count), 32'd2);
        idle("bp_pop1", 1);
        chk("bp.order", 32'(OutData), 32'h20);
        idle("bp_pop2", 1);

        // Flags follow accepted results.
        step("flag1", 1, 8'h00, 1, 1, 3'd0, 0, 1, 0, 1);
        chk("flag1.zero", 32'(ZeroFlag), 32'd1);
        chk("flag1.sc",   32'(SC_out),   32'd1);
        step("flag2", 1, 8'h05, 0, 0, 3'd0, 0, 0, 0, 1);
        chk("flag2.zero", 32'(ZeroFlag), 32'd0);
        chk("flag2.sc",   32'(SC_out),   32'd1);
        idle("flag_drain", 1);

        // Forward priority between older and younger entries.
        step("fwd_a1", 1, 8'h22, 0, 0, 3'd2, 1, 0, 0, 0);
        step("fwd_a2", 1, 8'h55, 0, 0, 3'd5, 0, 0, 0, 0);
        chk("fwd.older", 32'(FwdDest), 32'd2);
        idle("fwd_drain_a1", 1);
        idle("fwd_drain_a2", 1);
        step("fwd_b1", 1, 8'h22, 0, 0, 3'd2, 0, 0, 0, 0);
        step("fwd_b2", 1, 8'h55, 0, 0, 3'd5, 1, 0, 0, 0);
        chk("fwd.younger", 32'(FwdDest), 32'd5);
        idle("fwd_drain_b1", 1);
        idle("fwd_drain_b2", 1);

        // Simultaneous push and pop at Count=1.
        step("pp_a1", 1, 8'hA1, 0, 0, 3'd1, 1, 0, 0, 0);
        chk("pp.head_a1", 32'(OutData), 32'hA1);
        for (int i = 2; i <= 5; i++) begin
            step("pp", 1, 8'(8'hA0 + i), 0, 0, 3'(i), 1, 0, 0, 1);
            chk("pp.count", 32'(Count), 32'd1);
        end
        idle("pp_drain", 1);

        // Flush at Count=2 with a push in the same cycle.
        step("fl_p1", 1, 8'h77, 1, 1, 3'd7, 1, 1, 0, 0);
        step("fl_p2", 1, 8'h78, 0, 0, 3'd6, 1, 0, 0, 0);
        zf_save = ZeroFlag; sc_save = SC_out;
        step("flush", 1, 8'h99, 1, 0, 3'd1, 1, 1, 1, 1);
        chk("flush.count", 32'(Count), 32'd0);
        chk("flush.zero",  32'(ZeroFlag), 32'(zf_save));
        chk("flush.sc",    32'(SC_out),   32'(sc_save));
        idle("flush_after", 1);
        chk("flush.nopush", 32'(OutValid), 32'd0);

        // Randomized traffic; upstream holds an unaccepted request.
        iv = 0; d = 0; z = 0; sc = 0; r = 0; we = 0; scw = 0; fl = 0; ordy = 0;
        last_acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!(iv && !last_acc && !fl)) begin
                iv  = ($urandom_range(0, 9) < 7);
                d   = 8'($urandom);
                z   = 1'($urandom);
                sc  = 1'($urandom);
                r   = 3'($urandom);
                we  = 1'($urandom);
                scw = 1'($urandom);
            end
            fl   = ($urandom_range(0, 15) == 0);
            ordy = 1'($urandom);
            step("rand", iv, d, z, sc, r, we, scw, fl, ordy);
        end

        // Asynchronous reset mid-stream.
        step("pre_rst1", 1, 8'hC1, 1, 1, 3'd2, 1, 1, 0, 0);
        step("pre_rst2", 1, 8'hC2, 1, 1, 3'd3, 1, 1, 0, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        step("post_rst", 1, 8'h3C, 0, 1, 3'd4, 1, 1, 0, 1);
        idle("post_rst_pop", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
